// File: rtl/mmio_port_bank.sv
// -----------------------------------------------------------------------------
// mmio_port_bank
//
// Memory-mapped I/O decoder and port bank for the tinymips data bus. CPU data
// accesses are split between the data RAM and a small I/O window. The window
// holds NUM_PORTS registered output ports, NUM_PORTS synchronised input ports,
// sticky per-input change flags (write-1-to-clear), an interrupt mask and a
// sticky bus-error status.
//
// I/O word map (k = word offset from IO_BASE, N = NUM_PORTS):
//   0 .. N-1    OUT[k]     read/write
//   N .. 2N-1   IN[k-N]    synchronised input, read-only
//   2N          CHG        sticky change flags, write 1 to clear
//   2N+1        MASK       interrupt mask, bits N-1:0
//   2N+2        ERR        bit0 illegal write, bit1 misaligned I/O write;
//                          any aligned write clears both bits
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset       asynchronous active-high reset
//   we          CPU data write enable
//   addr        CPU data byte address
//   wd          CPU write data
//   port_in     external inputs, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dataram_we  data RAM write enable (combinational)
//   rd_sel      0: CPU reads RAM, 1: CPU reads io_rd (combinational)
//   io_rd       I/O read data, combinational from current register values
//   port_out    registered output ports, same packing as port_in
//   irq         registered interrupt request
// -----------------------------------------------------------------------------
module mmio_port_bank #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_PORTS   = 4,
    parameter logic [31:0] IO_BASE     = 32'h0000_2000,
    parameter logic [31:0] RAM_LIMIT   = 32'h0000_2000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            we,
    input  logic [31:0]                     addr,
    input  logic [DATA_WIDTH-1:0]           wd,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_in,
    output logic                            dataram_we,
    output logic                            rd_sel,
    output logic [DATA_WIDTH-1:0]           io_rd,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] port_out,
    output logic                            irq
);

    localparam int          NUM_WORDS = 2 * NUM_PORTS + 3;
    localparam logic [31:0] IO_END    = IO_BASE + 32'(4 * NUM_WORDS);
    localparam logic [29:0] IDX_IN    = 30'(NUM_PORTS);
    localparam logic [29:0] IDX_CHG   = 30'(2 * NUM_PORTS);
    localparam logic [29:0] IDX_MASK  = 30'(2 * NUM_PORTS + 1);
    localparam logic [29:0] IDX_ERR   = 30'(2 * NUM_PORTS + 2);
    // Change detection is armed once the synchronisers and the prev stage
    // have been refilled with real input samples after reset.
    localparam logic [2:0]  WARM_DONE = 3'(SYNC_STAGES + 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0] io_off;
    logic [29:0] word_idx;
    logic        in_io;
    logic        in_ram;
    logic        aligned;

    // IO_BASE is word aligned, so the low offset bits equal addr[1:0].
    assign io_off   = addr - IO_BASE;
    assign word_idx = io_off[31:2];
    assign aligned  = (io_off[1:0] == 2'b00);
    assign in_io    = (addr >= IO_BASE) && (addr < IO_END);
    assign in_ram   = (addr < RAM_LIMIT);

    // I/O wins when the RAM and I/O windows overlap.
    assign rd_sel     = in_io;
    assign dataram_we = we & in_ram & ~in_io;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic wr_io;
    logic wr_ok;
    logic err_misaligned;
    logic err_illegal;
    logic chg_wr;
    logic mask_wr;
    logic err_wr;

    assign wr_io          = we & in_io;
    assign wr_ok          = wr_io & aligned;
    assign err_misaligned = wr_io & ~aligned;
    // Illegal: a write to a read-only input word, or a write that hits
    // neither the I/O window nor the RAM.
    assign err_illegal    = (wr_ok & (word_idx >= IDX_IN) & (word_idx < IDX_CHG))
                          | (we & ~in_io & ~in_ram);
    assign chg_wr         = wr_ok & (word_idx == IDX_CHG);
    assign mask_wr        = wr_ok & (word_idx == IDX_MASK);
    assign err_wr         = wr_ok & (word_idx == IDX_ERR);

    // Low NUM_PORTS bits of the write data; bits beyond DATA_WIDTH are
    // zero when there are more ports than data bits.
    logic [NUM_PORTS-1:0] wd_bits;

    genvar gi;
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_wd_bits
        if (gi < DATA_WIDTH) begin : g_bit
            assign wd_bits[gi] = wd[gi];
        end else begin : g_zero
            assign wd_bits[gi] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Warm-up counter
    // ------------------------------------------------------------------
    logic [2:0] warm_reg;
    logic       warm_done;

    assign warm_done = (warm_reg == WARM_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_reg <= 3'd0;
        end else if (!warm_done) begin
            warm_reg <= warm_reg + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Per-port output registers and input synchronisers
    // ------------------------------------------------------------------
    logic [NUM_PORTS*DATA_WIDTH-1:0] sync_flat;
    logic [NUM_PORTS-1:0]            change;

    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic                  out_hit;
        logic [DATA_WIDTH-1:0] out_reg;
        logic [DATA_WIDTH-1:0] sync_reg [SYNC_STAGES];
        logic [DATA_WIDTH-1:0] prev_reg;

        assign out_hit = wr_ok && (word_idx == 30'(gi));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_reg <= '0;
            end else if (out_hit) begin
                out_reg <= wd;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s < SYNC_STAGES; s++) begin
                    sync_reg[s] <= '0;
                end
                prev_reg <= '0;
            end else begin
                sync_reg[0] <= port_in[gi*DATA_WIDTH +: DATA_WIDTH];
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_reg[s] <= sync_reg[s-1];
                end
                prev_reg <= sync_reg[SYNC_STAGES-1];
            end
        end

        assign port_out[gi*DATA_WIDTH +: DATA_WIDTH]  = out_reg;
        assign sync_flat[gi*DATA_WIDTH +: DATA_WIDTH] = sync_reg[SYNC_STAGES-1];
        assign change[gi] = warm_done && (sync_reg[SYNC_STAGES-1] != prev_reg);
    end

    // ------------------------------------------------------------------
    // CHG / MASK / ERR / irq
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] chg_reg;
    logic [NUM_PORTS-1:0] chg_next;
    logic [NUM_PORTS-1:0] mask_reg;
    logic [NUM_PORTS-1:0] mask_next;
    logic [1:0]           err_reg;
    logic [1:0]           err_next;
    logic                 irq_reg;

    always_comb begin
        chg_next  = chg_reg;
        mask_next = mask_reg;
        err_next  = err_reg;
        // Clear first, then set, so a fresh change beats a same-cycle W1C.
        if (chg_wr) begin
            chg_next = chg_next & ~wd_bits;
        end
        chg_next = chg_next | change;
        if (mask_wr) begin
            mask_next = wd_bits;
        end
        // Same ordering for ERR: a new error beats a same-cycle clear.
        if (err_wr) begin
            err_next = 2'b00;
        end
        err_next = err_next | {err_misaligned, err_illegal};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chg_reg  <= '0;
            mask_reg <= '0;
            err_reg  <= 2'b00;
            irq_reg  <= 1'b0;
        end else begin
            chg_reg  <= chg_next;
            mask_reg <= mask_next;
            err_reg  <= err_next;
            // Built from the next-state values so irq follows the flag or
            // mask update on the same edge.
            irq_reg  <= |(chg_next & mask_next);
        end
    end

    assign irq = irq_reg;

    // ------------------------------------------------------------------
    // Read mux (current register values; a same-cycle write is not seen)
    // ------------------------------------------------------------------
    always_comb begin
        io_rd = '0;
        if (in_io) begin
            if (word_idx < IDX_IN) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (word_idx == 30'(i)) begin
                        io_rd = port_out[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end else if (word_idx < IDX_CHG) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (word_idx == 30'(NUM_PORTS + i)) begin
                        io_rd = sync_flat[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end else if (word_idx == IDX_CHG) begin
                io_rd = DATA_WIDTH'(chg_reg);
            end else if (word_idx == IDX_MASK) begin
                io_rd = DATA_WIDTH'(mask_reg);
            end else begin
                io_rd = DATA_WIDTH'(err_reg);
            end
        end
    end

endmodule

// File: tb/tb_mmio_port_bank.sv
// -----------------------------------------------------------------------------
// tb_mmio_port_bank
//
// Directed bench for mmio_port_bank (N=4, 32-bit, IO_BASE=RAM_LIMIT=0x2000,
// SYNC_STAGES=2). A behavioural model tracks the register file and the input
// history; a compare process checks every output against it on each falling
// edge while out of reset. Hand-computed literal checks pin the key cases.
// -----------------------------------------------------------------------------
module tb_mmio_port_bank;

    localparam int          DW   = 32;
    localparam int          NP   = 4;
    localparam int          SS   = 2;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam logic [31:0] RLIM = 32'h0000_2000;
    localparam logic [31:0] IEND = BASE + 32'(4 * (2 * NP + 3));

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               we = 1'b0;
    logic [31:0]        addr = '0;
    logic [DW-1:0]      wd = '0;
    logic [NP*DW-1:0]   port_in = '0;
    logic               dataram_we;
    logic               rd_sel;
    logic [DW-1:0]      io_rd;
    logic [NP*DW-1:0]   port_out;
    logic               irq;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    mmio_port_bank #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .IO_BASE    (BASE),
        .RAM_LIMIT  (RLIM),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .addr      (addr),
        .wd        (wd),
        .port_in   (port_in),
        .dataram_we(dataram_we),
        .rd_sel    (rd_sel),
        .io_rd     (io_rd),
        .port_out  (port_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [DW-1:0]    m_out [NP];
    logic [NP-1:0]    m_chg;
    logic [NP-1:0]    m_mask;
    logic [1:0]       m_err;
    logic             m_irq;
    logic [NP*DW-1:0] m_hist [$];   // port_in as seen at each edge since reset
    int               m_edges;

    // Input value captured at edge j after reset (1-based); zero before that.
    function automatic logic [NP*DW-1:0] sampled(input int j);
        if (j < 1) return '0;
        return m_hist[j-1];
    endfunction

    function automatic bit is_io(input logic [31:0] a);
        return (a >= BASE) && (a < IEND);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_out[i] = '0;
        m_chg   = '0;
        m_mask  = '0;
        m_err   = 2'b00;
        m_irq   = 1'b0;
        m_hist.delete();
        m_edges = 0;
    endtask

    task automatic model_edge();
        logic [NP*DW-1:0] cur;
        logic [NP*DW-1:0] prv;
        logic [NP-1:0]    det;
        logic [NP-1:0]    clr;
        logic [NP-1:0]    mask_n;
        logic [NP-1:0]    chg_n;
        logic [1:0]       new_err;
        bit               clr_err;
        int               k;
        det = '0; clr = '0; new_err = 2'b00; clr_err = 1'b0; mask_n = m_mask;
        // The synchronised value lags the pin by SS edges; a change is seen
        // one edge later, and only once SS+1 edges have passed since reset.
        if (m_edges >= SS + 1) begin
            cur = sampled(m_edges - SS + 1);
            prv = sampled(m_edges - SS);
            for (int i = 0; i < NP; i++) det[i] = (cur[i*DW +: DW] != prv[i*DW +: DW]);
        end
        if (we && is_io(addr)) begin
            if (addr[1:0] != 2'b00) begin
                new_err[1] = 1'b1;
            end else begin
                k = int'((addr - BASE) >> 2);
                if (k < NP)               m_out[k] = wd;
                else if (k < 2 * NP)      new_err[0] = 1'b1;
                else if (k == 2 * NP)     clr = wd[NP-1:0];
                else if (k == 2 * NP + 1) mask_n = wd[NP-1:0];
                else                      clr_err = 1'b1;
            end
        end else if (we && !(addr < RLIM)) begin
            new_err[0] = 1'b1;
        end
        chg_n  = (m_chg & ~clr) | det;
        m_chg  = chg_n;
        m_mask = mask_n;
        m_err  = (clr_err ? 2'b00 : m_err) | new_err;
        m_irq  = |(chg_n & mask_n);
        m_hist.push_back(port_in);
        m_edges++;
    endtask

    function automatic logic [DW-1:0] m_read(input logic [31:0] a);
        int k;
        logic [NP*DW-1:0] s;
        if (!is_io(a)) return '0;
        k = int'((a - BASE) >> 2);
        if (k < NP) return m_out[k];
        if (k < 2 * NP) begin
            s = sampled(m_edges - SS + 1);
            return s[(k - NP)*DW +: DW];
        end
        if (k == 2 * NP)     return DW'(m_chg);
        if (k == 2 * NP + 1) return DW'(m_mask);
        return DW'(m_err);
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_edge();
        end
    end

    task automatic compare_all();
        logic [NP*DW-1:0] exp_po;
        for (int i = 0; i < NP; i++) exp_po[i*DW +: DW] = m_out[i];
        check("cyc_port_out",   128'(port_out),   128'(exp_po));
        check("cyc_irq",        128'(irq),        128'(m_irq));
        check("cyc_rd_sel",     128'(rd_sel),     128'(is_io(addr)));
        check("cyc_dataram_we", 128'(dataram_we), 128'(we && (addr < RLIM) && !is_io(addr)));
        check("cyc_io_rd",      128'(io_rd),      128'(m_read(addr)));
    endtask

    always @(negedge clk) begin
        if (run_cmp && !reset) compare_all();
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        we = w; addr = a; wd = d;
    endtask

    initial begin
        port_in[31:0] = 32'h5;
        repeat (3) @(posedge clk);
        #2;
        check("rst_port_out", 128'(port_out), 128'h0);
        check("rst_irq",      128'(irq),      128'h0);
        reset   = 1'b0;
        run_cmp = 1'b1;

        // Static nonzero input through reset release: no change flag.
        repeat (10) drive(1'b0, 32'h2020, 32'h0);
        #1 check("warmup_chg", 128'(io_rd), 128'h0);

        // OUT[2] write and read back.
        drive(1'b1, 32'h2008, 32'hA5);
        drive(1'b0, 32'h2008, 32'h0);
        #1;
        check("out2_port_out", 128'(port_out), {32'h0, 32'h0, 32'h0, 32'hA5, 32'h0, 32'h0});
        check("out2_rd_sel",   128'(rd_sel),   128'h1);
        check("out2_io_rd",    128'(io_rd),    128'hA5);

        // RAM write, then misaligned I/O write.
        drive(1'b1, 32'h0FFC, 32'h11);
        #1 check("ram_we", 128'(dataram_we), 128'h1);
        drive(1'b1, 32'h2002, 32'hFF);
        #1 check("mis_ram_we", 128'(dataram_we), 128'h0);
        drive(1'b0, 32'h2028, 32'h0);
        #1;
        check("err_misaligned", 128'(io_rd),    128'h2);
        check("mis_no_write",   128'(port_out), {32'h0, 32'h0, 32'h0, 32'hA5, 32'h0, 32'h0});

        // Clear, write IN1, write unmapped, clear again.
        drive(1'b1, 32'h2028, 32'h0);
        drive(1'b1, 32'h2014, 32'h1);
        drive(1'b0, 32'h2028, 32'h0);
        #1 check("err_in_write", 128'(io_rd), 128'h1);
        drive(1'b1, 32'h3000, 32'h1);
        #1 check("unmapped_ram_we", 128'(dataram_we), 128'h0);
        drive(1'b0, 32'h2028, 32'h0);
        #1 check("err_unmapped", 128'(io_rd), 128'h1);
        drive(1'b1, 32'h2028, 32'h0);
        drive(1'b0, 32'h2028, 32'h0);
        #1 check("err_cleared", 128'(io_rd), 128'h0);

        // MASK upper bits read zero, then enable port 0 only.
        drive(1'b1, 32'h2024, 32'hFFFF_FFFF);
        drive(1'b0, 32'h2024, 32'h0);
        #1 check("mask_upper_zero", 128'(io_rd), 128'hF);
        drive(1'b1, 32'h2024, 32'h1);

        // Input change: flag appears SS+1 edges later.
        drive(1'b0, 32'h2020, 32'h0);
        port_in[31:0] = 32'h6;
        drive(1'b0, 32'h2020, 32'h0);
        #1 check("chg_edge1", 128'(io_rd), 128'h0);
        drive(1'b0, 32'h2020, 32'h0);
        #1 check("chg_edge2", 128'(io_rd), 128'h0);
        drive(1'b0, 32'h2020, 32'h0);
        #1 check("chg_edge3", 128'(io_rd), 128'h1);
        drive(1'b0, 32'h2010, 32'h0);
        #1;
        check("irq_after_chg", 128'(irq),   128'h1);
        check("in0_read",      128'(io_rd), 128'h6);

        // W1C landing on the same edge as a new change: set wins.
        drive(1'b0, 32'h2020, 32'h0);
        port_in[31:0] = 32'h7;
        drive(1'b0, 32'h2020, 32'h0);
        drive(1'b1, 32'h2020, 32'h1);
        drive(1'b0, 32'h2020, 32'h0);
        #1;
        check("w1c_race_chg", 128'(io_rd), 128'h1);
        check("w1c_race_irq", 128'(irq),   128'h1);

        // Clean W1C.
        drive(1'b1, 32'h2020, 32'h1);
        drive(1'b0, 32'h2020, 32'h0);
        #1;
        check("w1c_chg", 128'(io_rd), 128'h0);
        check("w1c_irq", 128'(irq),   128'h0);

        // Unmasked port change: flag only, no irq.
        drive(1'b0, 32'h2020, 32'h0);
        port_in[127:96] = 32'h9;
        repeat (4) drive(1'b0, 32'h2020, 32'h0);
        #1;
        check("unmasked_chg", 128'(io_rd), 128'h8);
        check("unmasked_irq", 128'(irq),   128'h0);

        // Build OUT[1]=0x33 and CHG=0xF, then reset in the middle of a write.
        drive(1'b1, 32'h2004, 32'h33);
        drive(1'b0, 32'h2020, 32'h0);
        port_in = {32'h1, 32'h2, 32'h3, 32'h4};
        repeat (4) drive(1'b0, 32'h2020, 32'h0);
        #1;
        check("pre_rst_chg",  128'(io_rd),           128'hF);
        check("pre_rst_out1", 128'(port_out[63:32]), 128'h33);
        check("pre_rst_irq",  128'(irq),             128'h1);
        drive(1'b1, 32'h2024, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("async_port_out", 128'(port_out), 128'h0);
        check("async_irq",      128'(irq),      128'h0);
        check("async_mask",     128'(io_rd),    128'h0);
        we = 1'b0; addr = 32'h2020;
        #1 check("async_chg", 128'(io_rd), 128'h0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Nonzero static inputs across this release: still no flag.
        repeat (6) drive(1'b0, 32'h2020, 32'h0);
        #1 check("rerelease_chg", 128'(io_rd), 128'h0);
        drive(1'b0, 32'h2020, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
